// File: rtl/port_io_bridge.sv
// External-device bridge for the CPU InPort/OutPort: DEPTH-entry input FIFO and one-word output holding register.
// Latency: pushed word visible on InPortData the cycle after the push; ext_out_valid rises the cycle after OutPortIn.
// Backpressure: ext_in_ready drops when the FIFO is full; the output is never stalled, so an unacked overwrite sets overrun. Optional: IO_LOOPBACK_EN.
module port_io_bridge #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] ext_in_data,
    input  logic             ext_in_valid,
    output logic             ext_in_ready,
    input  logic             InPortIn,
    output logic [WIDTH-1:0] InPortData,
    output logic             in_empty,
    input  logic             OutPortIn,
    input  logic [WIDTH-1:0] BusMuxOut,
    output logic [WIDTH-1:0] ext_out_data,
    output logic             ext_out_valid,
    input  logic             ext_out_ack,
    output logic             out_busy,
    output logic             overrun
`ifdef IO_LOOPBACK_EN
    ,
    input  logic             loopback
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_out_dat;
    logic             r_overrun;
    state_t           r_state;
    state_t           w_state_nxt;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_push_dat;
    logic             w_load;
    logic             w_ovr_set;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = InPortIn && !w_empty;

    // Push source selection; loopback diverts OutPort writes into the input FIFO.
    always_comb begin
        ext_in_ready = !w_full;
        w_push       = ext_in_valid && !w_full;
        w_push_dat   = ext_in_data;
`ifdef IO_LOOPBACK_EN
        if (loopback) begin
            ext_in_ready = 1'b0;
            w_push       = OutPortIn && !w_full;
            w_push_dat   = BusMuxOut;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_push_dat;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign InPortData = w_empty ? '0 : r_mem[r_rptr];
    assign in_empty   = w_empty;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (OutPortIn) w_state_nxt = PEND;
            PEND:    if (!OutPortIn && ext_out_ack) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
`ifdef IO_LOOPBACK_EN
        if (loopback) w_state_nxt = IDLE;
`endif
    end

    always_comb begin
        ext_out_valid = (r_state == PEND);
        out_busy      = (r_state == PEND);
        w_load        = OutPortIn;
        w_ovr_set     = (r_state == PEND) && OutPortIn && !ext_out_ack;
`ifdef IO_LOOPBACK_EN
        if (loopback) w_ovr_set = OutPortIn && w_full;
`endif
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_out_dat <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load)    r_out_dat <= BusMuxOut;
            if (w_ovr_set) r_overrun <= 1'b1;
        end
    end

    assign ext_out_data = r_out_dat;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_port_io_bridge.sv
// Directed bench for port_io_bridge (default build): FIFO fill/drain, wrap, output handshake, async reset.
module tb_port_io_bridge;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] ext_in_data;
    logic        ext_in_valid;
    logic        ext_in_ready;
    logic        InPortIn;
    logic [31:0] InPortData;
    logic        in_empty;
    logic        OutPortIn;
    logic [31:0] BusMuxOut;
    logic [31:0] ext_out_data;
    logic        ext_out_valid;
    logic        ext_out_ack;
    logic        out_busy;
    logic        overrun;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    port_io_bridge #(.WIDTH(32), .DEPTH(4)) dut (
        .clk          (clk),
        .clr          (clr),
        .ext_in_data  (ext_in_data),
        .ext_in_valid (ext_in_valid),
        .ext_in_ready (ext_in_ready),
        .InPortIn     (InPortIn),
        .InPortData   (InPortData),
        .in_empty     (in_empty),
        .OutPortIn    (OutPortIn),
        .BusMuxOut    (BusMuxOut),
        .ext_out_data (ext_out_data),
        .ext_out_valid(ext_out_valid),
        .ext_out_ack  (ext_out_ack),
        .out_busy     (out_busy),
        .overrun      (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 32'(ext_in_ready), 32'd1);
        chk({tag, "_empty"}, 32'(in_empty), 32'd1);
        chk({tag, "_indata"}, InPortData, 32'd0);
        chk({tag, "_outdata"}, ext_out_data, 32'd0);
        chk({tag, "_valid"}, 32'(ext_out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(out_busy), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    logic [31:0] fill_v [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    logic [31:0] pop_v  [4] = '{32'h22, 32'h33, 32'h44, 32'h0};

    initial begin
        clr = 1'b1; ext_in_data = '0; ext_in_valid = 1'b0; InPortIn = 1'b0;
        OutPortIn = 1'b0; BusMuxOut = '0; ext_out_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("rst");
        clr = 1'b0;

        // Fill to full, then offer a fifth word.
        ext_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ext_in_data = fill_v[i];
            if (i == 3) chk("ready_before_4th", 32'(ext_in_ready), 32'd1);
            @(negedge clk);
        end
        chk("ready_full", 32'(ext_in_ready), 32'd0);
        ext_in_data = 32'h55;
        @(negedge clk);
        chk("ready_full_hold", 32'(ext_in_ready), 32'd0);
        chk("head_full", InPortData, 32'h11);
        chk("empty_full", 32'(in_empty), 32'd0);
        ext_in_valid = 1'b0;

        // Drain; 0x55 must not have entered.
        InPortIn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("pop%0d", i), InPortData, pop_v[i]);
            if (i == 0) chk("ready_after_pop", 32'(ext_in_ready), 32'd1);
        end
        chk("empty_drained", 32'(in_empty), 32'd1);
        @(negedge clk);
        chk("pop_empty_data", InPortData, 32'd0);
        chk("pop_empty_flag", 32'(in_empty), 32'd1);
        InPortIn = 1'b0;
        ext_in_valid = 1'b1; ext_in_data = 32'h66;
        @(negedge clk);
        ext_in_valid = 1'b0;
        chk("rptr_unmoved", InPortData, 32'h66);
        InPortIn = 1'b1;
        @(negedge clk);
        InPortIn = 1'b0;
        chk("empty_again", 32'(in_empty), 32'd1);

        // Half full, then simultaneous push/pop across wrap.
        ext_in_valid = 1'b1; ext_in_data = 32'hA0;
        @(negedge clk);
        ext_in_data = 32'hA1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("pp_head%0d", i), InPortData,
                (i == 0) ? 32'hA0 : (i == 1) ? 32'hA1 : 32'h100 + 32'(i - 2));
            chk($sformatf("pp_ready%0d", i), 32'(ext_in_ready), 32'd1);
            ext_in_data = 32'h100 + 32'(i);
            InPortIn = 1'b1;
            @(negedge clk);
        end
        ext_in_valid = 1'b0;
        chk("pp_tail0", InPortData, 32'h108);
        @(negedge clk);
        chk("pp_tail1", InPortData, 32'h109);
        @(negedge clk);
        chk("pp_drained", 32'(in_empty), 32'd1);
        InPortIn = 1'b0;

        // Output handshake.
        BusMuxOut = 32'hDEADBEEF; OutPortIn = 1'b1;
        chk("out_idle_valid", 32'(ext_out_valid), 32'd0);
        @(negedge clk);
        OutPortIn = 1'b0;
        chk("out_valid", 32'(ext_out_valid), 32'd1);
        chk("out_busy", 32'(out_busy), 32'd1);
        chk("out_data", ext_out_data, 32'hDEADBEEF);
        @(negedge clk);
        chk("out_hold_valid", 32'(ext_out_valid), 32'd1);
        ext_out_ack = 1'b1;
        @(negedge clk);
        chk("ack_valid", 32'(ext_out_valid), 32'd0);
        chk("ack_busy", 32'(out_busy), 32'd0);
        chk("ack_data_held", ext_out_data, 32'hDEADBEEF);
        @(negedge clk);
        ext_out_ack = 1'b0;
        chk("idle_ack_ignored", 32'(ext_out_valid), 32'd0);

        // Overwrite rules in PEND.
        BusMuxOut = 32'hCAFE0001; OutPortIn = 1'b1;
        @(negedge clk);
        BusMuxOut = 32'h0BADF00D; ext_out_ack = 1'b1;
        @(negedge clk);
        chk("wr_ack_data", ext_out_data, 32'h0BADF00D);
        chk("wr_ack_valid", 32'(ext_out_valid), 32'd1);
        chk("wr_ack_no_ovr", 32'(overrun), 32'd0);
        BusMuxOut = 32'h12345678; ext_out_ack = 1'b0;
        @(negedge clk);
        chk("ovr_data", ext_out_data, 32'h12345678);
        chk("ovr_set", 32'(overrun), 32'd1);
        BusMuxOut = 32'h9ABCDEF0; ext_out_ack = 1'b1;
        @(negedge clk);
        OutPortIn = 1'b0; ext_out_ack = 1'b0;
        chk("ovr_sticky", 32'(overrun), 32'd1);
        chk("ovr_ack_valid", 32'(ext_out_valid), 32'd1);
        chk("ovr_ack_data", ext_out_data, 32'h9ABCDEF0);

        // Three FIFO entries plus pending output, then asynchronous clear.
        ext_in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            ext_in_data = 32'(i);
            @(negedge clk);
        end
        ext_in_valid = 1'b0;
        chk("pre_clr_head", InPortData, 32'h1);
        chk("pre_clr_valid", 32'(ext_out_valid), 32'd1);
        @(posedge clk);
        #2 clr = 1'b1;
        #1 chk_reset("aclr");
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        chk_reset("post_clr");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
